// File: rtl/io_writeback_arbiter_if.sv
// Handshake bundle between the IO response sources, the writeback arbiter
// and the register-file writeback consumer.
// master: the arbiter's view. slave: the view of whatever surrounds it
// (sources on the input side, the register file on the output side).
interface io_writeback_arbiter_if #(
    parameter int DATABITWIDTH    = 16,
    parameter int INPUTPORTCOUNT  = 20,
    parameter int PORTADDRWIDTH   = $clog2(INPUTPORTCOUNT),
    parameter int REGADDRBITWIDTH = 4
) ();
    logic [INPUTPORTCOUNT-1:0]                      InputACK;
    logic [INPUTPORTCOUNT-1:0]                      InputREQ;
    logic [INPUTPORTCOUNT-1:0][REGADDRBITWIDTH-1:0] InputDestReg;
    logic [INPUTPORTCOUNT-1:0][DATABITWIDTH-1:0]    InputData;
    logic                                           OutputACK;
    logic                                           OutputREQ;
    logic [REGADDRBITWIDTH-1:0]                     OutputDestReg;
    logic [DATABITWIDTH-1:0]                        OutputData;
    logic [PORTADDRWIDTH-1:0]                       OutputSrcIndex;

    modport master (
        input  InputACK, InputDestReg, InputData, OutputREQ,
        output InputREQ, OutputACK, OutputDestReg, OutputData, OutputSrcIndex
    );

    modport slave (
        output InputACK, InputDestReg, InputData, OutputREQ,
        input  InputREQ, OutputACK, OutputDestReg, OutputData, OutputSrcIndex
    );
endinterface

// File: rtl/io_writeback_arbiter.sv
// Round-robin arbiter sharing the single IO writeback port among all IO
// response sources. One winner per cycle is captured into a registered
// output slot; the slot can drain and refill on the same edge, so a full
// stream sustains one writeback per cycle.
module io_writeback_arbiter #(
    parameter int DATABITWIDTH    = 16,
    parameter int INPUTPORTCOUNT  = 20,
    parameter int PORTADDRWIDTH   = $clog2(INPUTPORTCOUNT),
    parameter int REGADDRBITWIDTH = 4
) (
    input  logic                    sys_clk,
    input  logic                    async_rst,
    input  logic                    clk_en,
    input  logic                    sync_rst,
    io_writeback_arbiter_if.master  bus
);
    localparam logic [PORTADDRWIDTH-1:0] LASTIDX = PORTADDRWIDTH'(INPUTPORTCOUNT - 1);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slotState_t;

    slotState_t                 slotStateReg, slotStateNext;
    logic [REGADDRBITWIDTH-1:0] slotDestReg, slotDestNext;
    logic [DATABITWIDTH-1:0]    slotDataReg, slotDataNext;
    logic [PORTADDRWIDTH-1:0]   slotSrcReg, slotSrcNext;
    logic [PORTADDRWIDTH-1:0]   pointerReg, pointerNext;

    logic                       slotFull;
    logic                       accept;
    logic                       grantValid;
    logic [INPUTPORTCOUNT-1:0]  upperMask;
    logic [INPUTPORTCOUNT-1:0]  upperAck;
    logic                       upperFound, lowerFound;
    logic [PORTADDRWIDTH-1:0]   upperIdx, lowerIdx, winnerIdx;

    assign slotFull = (slotStateReg == SLOT_FULL);

    // Sources at or above the pointer form the first search window; if none
    // of them is valid the search wraps to the lowest valid source overall.
    genvar gi;
    generate
        for (gi = 0; gi < INPUTPORTCOUNT; gi++) begin : g_mask
            assign upperMask[gi] = (PORTADDRWIDTH'(gi) >= pointerReg);
        end
    endgenerate

    assign upperAck = bus.InputACK & upperMask;

    // Lowest-index valid source in each window (upper window wins).
    always_comb begin
        upperFound = 1'b0;
        upperIdx   = '0;
        lowerFound = 1'b0;
        lowerIdx   = '0;
        for (int i = INPUTPORTCOUNT - 1; i >= 0; i--) begin
            if (upperAck[i]) begin
                upperFound = 1'b1;
                upperIdx   = PORTADDRWIDTH'(i);
            end
            if (bus.InputACK[i]) begin
                lowerFound = 1'b1;
                lowerIdx   = PORTADDRWIDTH'(i);
            end
        end
        winnerIdx = upperFound ? upperIdx : lowerIdx;
    end

    // The slot can take a new entry when it is empty or is being consumed now.
    assign accept     = clk_en & ~sync_rst & (~slotFull | bus.OutputREQ);
    assign grantValid = accept & lowerFound;

    // One-hot ready back to the winning source only.
    generate
        for (gi = 0; gi < INPUTPORTCOUNT; gi++) begin : g_req
            assign bus.InputREQ[gi] = grantValid & (winnerIdx == PORTADDRWIDTH'(gi));
        end
    endgenerate

    // Next slot contents and pointer: load on a grant, otherwise drain if consumed.
    always_comb begin
        slotStateNext = slotStateReg;
        slotDestNext  = slotDestReg;
        slotDataNext  = slotDataReg;
        slotSrcNext   = slotSrcReg;
        pointerNext   = pointerReg;
        if (grantValid) begin
            slotStateNext = SLOT_FULL;
            slotDestNext  = bus.InputDestReg[winnerIdx];
            slotDataNext  = bus.InputData[winnerIdx];
            slotSrcNext   = winnerIdx;
            pointerNext   = (winnerIdx == LASTIDX) ? '0 : winnerIdx + 1'b1;
        end else if (slotFull && bus.OutputREQ) begin
            slotStateNext = SLOT_EMPTY;
        end
    end

    // State register: async clear, then clock-enabled sync clear or update.
    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            slotStateReg <= SLOT_EMPTY;
            slotDestReg  <= '0;
            slotDataReg  <= '0;
            slotSrcReg   <= '0;
            pointerReg   <= '0;
        end else if (clk_en) begin
            if (sync_rst) begin
                slotStateReg <= SLOT_EMPTY;
                slotDestReg  <= '0;
                slotDataReg  <= '0;
                slotSrcReg   <= '0;
                pointerReg   <= '0;
            end else begin
                slotStateReg <= slotStateNext;
                slotDestReg  <= slotDestNext;
                slotDataReg  <= slotDataNext;
                slotSrcReg   <= slotSrcNext;
                pointerReg   <= pointerNext;
            end
        end
    end

    assign bus.OutputACK      = slotFull;
    assign bus.OutputDestReg  = slotDestReg;
    assign bus.OutputData     = slotDataReg;
    assign bus.OutputSrcIndex = slotSrcReg;
endmodule

// File: tb/tb_io_writeback_arbiter.sv
// Bench for io_writeback_arbiter: directed vector table, hand-written reset
// sequence, then randomized traffic against a queue-style reference model.
module tb_io_writeback_arbiter;
    localparam int DW = 16;
    localparam int N  = 20;
    localparam int AW = $clog2(N);
    localparam int RW = 4;

    logic sys_clk = 1'b0;
    logic async_rst;
    logic clk_en;
    logic sync_rst;

    io_writeback_arbiter_if #(.DATABITWIDTH(DW), .INPUTPORTCOUNT(N),
                              .PORTADDRWIDTH(AW), .REGADDRBITWIDTH(RW)) bus ();

    io_writeback_arbiter #(.DATABITWIDTH(DW), .INPUTPORTCOUNT(N),
                           .PORTADDRWIDTH(AW), .REGADDRBITWIDTH(RW)) dut (
        .sys_clk   (sys_clk),
        .async_rst (async_rst),
        .clk_en    (clk_en),
        .sync_rst  (sync_rst),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0]  ack;
        logic          oreq;
        logic          ce;
        logic          srst;
        logic [N-1:0]  expReq;
        logic          expAck;
        logic [AW-1:0] expSrc;
        logic [RW-1:0] expDest;
        logic [DW-1:0] expData;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [N-1:0] ack, input logic oreq, input logic ce,
                       input logic srst, input logic [N-1:0] req, input logic eAck,
                       input logic [AW-1:0] eSrc, input logic [RW-1:0] eDest,
                       input logic [DW-1:0] eData);
        vec_t v;
        v = '{ack, oreq, ce, srst, req, eAck, eSrc, eDest, eData};
        vecs.push_back(v);
    endtask

    // Reference model state (values after the most recent edge).
    bit            mValid;
    logic [RW-1:0] mDest;
    logic [DW-1:0] mData;
    int            mSrc;
    int            mPtr;
    bit            pend [N];
    logic [DW-1:0] pData [N];
    logic [RW-1:0] pDest [N];

    initial begin
        async_rst     = 1'b1;
        clk_en        = 1'b1;
        sync_rst      = 1'b0;
        bus.InputACK  = '0;
        bus.OutputREQ = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.InputData[i]    = 16'hD000 + 16'(i);
            bus.InputDestReg[i] = 4'(i);
        end
        bus.InputData[5]    = 16'hBEEF;
        bus.InputDestReg[5] = 4'h3;

        // ack, oreq, ce, srst | InputREQ, then after edge: ACK, src, dest, data
        add(20'h80081, 1, 1, 0, 20'h00001, 1, 5'd0,  4'd0, 16'hD000);
        add(20'h80081, 1, 1, 0, 20'h00080, 1, 5'd7,  4'd7, 16'hD007);
        add(20'h80081, 1, 1, 0, 20'h80000, 1, 5'd19, 4'd3, 16'hD013);
        add(20'h80081, 1, 1, 0, 20'h00001, 1, 5'd0,  4'd0, 16'hD000);
        add(20'h80081, 1, 1, 0, 20'h00080, 1, 5'd7,  4'd7, 16'hD007);
        add(20'h00020, 1, 1, 0, 20'h00020, 1, 5'd5,  4'd3, 16'hBEEF);
        add(20'h00060, 1, 1, 0, 20'h00040, 1, 5'd6,  4'd6, 16'hD006);
        add(20'h40000, 1, 1, 0, 20'h40000, 1, 5'd18, 4'd2, 16'hD012);
        add(20'h80022, 1, 1, 0, 20'h80000, 1, 5'd19, 4'd3, 16'hD013);
        add(20'h00022, 1, 1, 0, 20'h00002, 1, 5'd1,  4'd1, 16'hD001);
        add(20'h0002A, 1, 1, 0, 20'h00008, 1, 5'd3,  4'd3, 16'hD003);
        add(20'h00022, 1, 1, 0, 20'h00020, 1, 5'd5,  4'd3, 16'hBEEF);
        add(20'h00002, 1, 1, 0, 20'h00002, 1, 5'd1,  4'd1, 16'hD001);
        for (int k = 0; k < 4; k++)
            add(20'h00004, 0, 1, 0, 20'h00000, 1, 5'd1, 4'd1, 16'hD001);
        add(20'h00004, 1, 1, 0, 20'h00004, 1, 5'd2,  4'd2, 16'hD002);
        for (int k = 0; k < 3; k++)
            add(20'h00010, 1, 0, 0, 20'h00000, 1, 5'd2, 4'd2, 16'hD002);
        add(20'h00010, 1, 1, 0, 20'h00010, 1, 5'd4,  4'd4, 16'hD004);
        add(20'h00000, 1, 1, 0, 20'h00000, 0, 5'd4,  4'd4, 16'hD004);
        add(20'h00200, 1, 1, 0, 20'h00200, 1, 5'd9,  4'd9, 16'hD009);
        add(20'h01200, 1, 1, 1, 20'h00000, 0, 5'd0,  4'd0, 16'h0000);
        add(20'hFFFFF, 1, 1, 0, 20'h00001, 1, 5'd0,  4'd0, 16'hD000);
        add(20'h00000, 0, 1, 0, 20'h00000, 1, 5'd0,  4'd0, 16'hD000);
        add(20'h00000, 1, 1, 0, 20'h00000, 0, 5'd0,  4'd0, 16'hD000);

        // Reset state
        #12;
        check("reset_ack",  32'(bus.OutputACK), 32'd0);
        check("reset_data", 32'(bus.OutputData), 32'd0);
        check("reset_dest", 32'(bus.OutputDestReg), 32'd0);
        check("reset_src",  32'(bus.OutputSrcIndex), 32'd0);
        check("reset_req",  32'(bus.InputREQ), 32'd0);
        async_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // Directed vector table
        foreach (vecs[r]) begin
            bus.InputACK  = vecs[r].ack;
            bus.OutputREQ = vecs[r].oreq;
            clk_en        = vecs[r].ce;
            sync_rst      = vecs[r].srst;
            @(negedge sys_clk);
            check($sformatf("vec%0d_req", r), 32'(bus.InputREQ), 32'(vecs[r].expReq));
            @(posedge sys_clk);
            #1;
            check($sformatf("vec%0d_ack", r),  32'(bus.OutputACK), 32'(vecs[r].expAck));
            check($sformatf("vec%0d_src", r),  32'(bus.OutputSrcIndex), 32'(vecs[r].expSrc));
            check($sformatf("vec%0d_dest", r), 32'(bus.OutputDestReg), 32'(vecs[r].expDest));
            check($sformatf("vec%0d_data", r), 32'(bus.OutputData), 32'(vecs[r].expData));
            $display("vec %0d: ack=%h oreq=%0d ce=%0d srst=%0d -> req=%h out=%0d src=%0d data=%h",
                     r, vecs[r].ack, vecs[r].oreq, vecs[r].ce, vecs[r].srst,
                     bus.InputREQ, bus.OutputACK, bus.OutputSrcIndex, bus.OutputData);
        end

        // Async reset mid-cycle with a full slot, then pointer must be back at 0
        bus.InputACK  = 20'h00200;
        bus.OutputREQ = 1'b0;
        @(negedge sys_clk);
        check("async_pre_req", 32'(bus.InputREQ), 32'h00200);
        @(posedge sys_clk);
        #1;
        check("async_pre_ack", 32'(bus.OutputACK), 32'd1);
        bus.InputACK = '0;
        #1 async_rst = 1'b1;
        #1;
        check("async_ack",  32'(bus.OutputACK), 32'd0);
        check("async_data", 32'(bus.OutputData), 32'd0);
        check("async_src",  32'(bus.OutputSrcIndex), 32'd0);
        #1 async_rst = 1'b0;
        bus.InputACK  = 20'hFFFFF;
        bus.OutputREQ = 1'b1;
        @(negedge sys_clk);
        check("async_ptr_req", 32'(bus.InputREQ), 32'h00001);
        @(posedge sys_clk);
        #1;
        check("async_post_src", 32'(bus.OutputSrcIndex), 32'd0);
        $display("async reset sequence: src=%0d data=%h", bus.OutputSrcIndex, bus.OutputData);

        // Randomized traffic against the reference model
        bus.InputACK = '0;
        async_rst    = 1'b1;
        #2 async_rst = 1'b0;
        mValid = 0; mDest = '0; mData = '0; mSrc = 0; mPtr = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; pData[i] = '0; pDest[i] = '0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [N-1:0] expReq;
            bit accept, found;
            int win;
            logic ce, sr, oreq;
            ce   = ($urandom_range(0, 9) != 0);
            sr   = ($urandom_range(0, 49) == 0);
            oreq = ($urandom_range(0, 3) != 0);
            clk_en = ce; sync_rst = sr; bus.OutputREQ = oreq;
            for (int i = 0; i < N; i++) begin
                bus.InputACK[i]     = pend[i];
                bus.InputData[i]    = pData[i];
                bus.InputDestReg[i] = pDest[i];
            end
            @(negedge sys_clk);
            accept = ce && !sr && (!mValid || oreq);
            found = 0; win = 0;
            if (accept) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && pend[(mPtr + k) % N]) begin
                        found = 1;
                        win = (mPtr + k) % N;
                    end
                end
            end
            expReq = '0;
            if (found) expReq[win] = 1'b1;
            check("rnd_req",  32'(bus.InputREQ), 32'(expReq));
            check("rnd_ack",  32'(bus.OutputACK), 32'(mValid));
            check("rnd_data", 32'(bus.OutputData), 32'(mData));
            check("rnd_dest", 32'(bus.OutputDestReg), 32'(mDest));
            check("rnd_src",  32'(bus.OutputSrcIndex), 32'(mSrc));
            if (ce) begin
                if (sr) begin
                    mValid = 0; mDest = '0; mData = '0; mSrc = 0; mPtr = 0;
                end else if (found) begin
                    mValid = 1; mDest = pDest[win]; mData = pData[win]; mSrc = win;
                    mPtr = (win + 1) % N;
                    pend[win] = 0;
                end else if (mValid && oreq) begin
                    mValid = 0;
                end
            end
            @(posedge sys_clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1;
                    pData[i] = 16'($urandom);
                    pDest[i] = 4'($urandom);
                end
            end
        end
        $display("random phase: 2000 cycles done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
